ap_ctrl_txn_recorder: RTL and testbench

- Synthesizable recorder that sits directly upstream of the dataflow status monitor/dumper.
- Watches one HLS block's ap_ctrl_hs handshake (ap_start, ap_ready, ap_done, ap_continue) and converts it into per-transaction records: start timestamp, latency, start-to-start interval and flags.
- Records are buffered in a FWFT FIFO drained over a valid/ready port.
- One instance per monitored block; the consumer dumps one line per record.

---
 rtl/ap_ctrl_txn_recorder_pkg.sv | 41 ++++
 rtl/ap_ctrl_txn_recorder_if.sv | 36 +++
 rtl/ap_ctrl_txn_recorder_fifo.sv | 53 +++++
 rtl/ap_ctrl_txn_recorder.sv | 183 ++++++++++++++++++
 tb/tb_ap_ctrl_txn_recorder.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ap_ctrl_txn_recorder_pkg.sv
// Shared types and record layout for the ap_ctrl_hs transaction recorder.
// The optional stall field is controlled by AP_TXN_STALL_COUNT_EN.
package ap_txn_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    DONE_WAIT = 2'd2,
    FINISHED  = 2'd3
  } txn_state_e;

`ifdef AP_TXN_STALL_COUNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  // Record layout, LSB first: start_ts, latency, interval, [stall], incomplete
  localparam int unsigned START_LSB = 0;

  function automatic int unsigned rec_w(input int unsigned ts_w);
    return (STALL_EN ? 4 : 3) * ts_w + 1;
  endfunction

  function automatic int unsigned lat_lsb(input int unsigned ts_w);
    return ts_w;
  endfunction

  function automatic int unsigned ivl_lsb(input int unsigned ts_w);
    return 2 * ts_w;
  endfunction

  function automatic int unsigned stall_lsb(input int unsigned ts_w);
    return 3 * ts_w;
  endfunction

  function automatic int unsigned inc_bit(input int unsigned ts_w);
    return rec_w(ts_w) - 1;
  endfunction

endpackage

// File: rtl/ap_ctrl_txn_recorder_if.sv
// Handshake, record stream and status signals of one recorder instance.
interface ap_ctrl_txn_recorder_if
  import ap_txn_pkg::*;
#(
  parameter int unsigned TS_W  = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned REC_W = rec_w(TS_W);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_continue;
  logic             finish;
  logic             rec_valid;
  logic             rec_ready;
  logic [REC_W-1:0] rec_data;
  logic             busy;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] txn_cnt;
  logic             proto_err;

  modport master (
    output ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready,
    input  rec_valid, rec_data, busy, fifo_level, overflow, drop_cnt, txn_cnt, proto_err
  );

  modport slave (
    input  ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready,
    output rec_valid, rec_data, busy, fifo_level, overflow, drop_cnt, txn_cnt, proto_err
  );
endinterface

// File: rtl/ap_ctrl_txn_recorder_fifo.sv
// First-word-fall-through FIFO: head word visible on rdata whenever not empty.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_push_c;
  logic             do_pop_c;

  assign full      = (level_q == LVL_W'(DEPTH));
  assign empty     = (level_q == '0);
  assign level     = level_q;
  assign rdata     = mem[rd_ptr_q];
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign do_pop_c  = pop & ~empty;
  assign do_push_c = push & (~full | do_pop_c);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push_c) begin
        mem[wr_ptr_q] <= wdata;
        wr_ptr_q      <= wr_ptr_q + AW'(1);
      end
      if (do_pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// File: rtl/ap_ctrl_txn_recorder.sv
// Converts one block's ap_ctrl_hs handshake into timestamped transaction records.
// Define AP_TXN_STALL_COUNT_EN to add the per-transaction stall-cycle field.
module ap_ctrl_txn_recorder
  import ap_txn_pkg::*;
#(
  parameter int unsigned TS_W  = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input logic                   clock,
  input logic                   reset,
  ap_ctrl_txn_recorder_if.slave bus
);
  localparam int unsigned REC_W   = rec_w(TS_W);
  localparam int unsigned LAT_LSB = lat_lsb(TS_W);
  localparam int unsigned IVL_LSB = ivl_lsb(TS_W);
  localparam int unsigned INC_BIT = inc_bit(TS_W);

  txn_state_e       state_q, state_d;
  logic [TS_W-1:0]  ts_q;
  logic [TS_W-1:0]  start_ts_q;
  logic [TS_W-1:0]  prev_start_q;
  logic             prev_valid_q;
  logic [TS_W-1:0]  interval_q;
  logic [TS_W-1:0]  latency_q;
  logic [CNT_W-1:0] txn_cnt_q;
  logic [CNT_W-1:0] drop_cnt_q;
  logic             overflow_q;
  logic             proto_err_q;

  logic             push_c, pop_c, full_c, empty_c, drop_c;
  logic             take_start_c, cap_lat_c, proto_c, rec_inc_c;
  logic [TS_W-1:0]  ivl_now_c, rec_start_c, rec_lat_c, rec_ivl_c;
  logic [REC_W-1:0] rec_c;

  assign ivl_now_c = prev_valid_q ? (ts_q - prev_start_q) : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state plus the record presented to the FIFO on a push
  always_comb begin
    state_d      = state_q;
    push_c       = 1'b0;
    take_start_c = 1'b0;
    cap_lat_c    = 1'b0;
    proto_c      = 1'b0;
    rec_inc_c    = 1'b0;
    rec_start_c  = start_ts_q;
    rec_lat_c    = latency_q;
    rec_ivl_c    = interval_q;
    case (state_q)
      IDLE: begin
        if (bus.finish) begin
          state_d = FINISHED;
        end else if (bus.ap_start) begin
          take_start_c = 1'b1;
          cap_lat_c    = 1'b1;
          rec_start_c  = ts_q;
          rec_lat_c    = '0;
          rec_ivl_c    = ivl_now_c;
          if (bus.ap_done && bus.ap_continue) push_c  = 1'b1;
          else if (bus.ap_done)               state_d = DONE_WAIT;
          else                                state_d = RUN;
        end else if (bus.ap_done || bus.ap_ready) begin
          proto_c = 1'b1;
        end
      end
      RUN: begin
        if (bus.finish) begin
          push_c    = 1'b1;
          rec_inc_c = 1'b1;
          rec_lat_c = ts_q - start_ts_q;
          state_d   = FINISHED;
        end else if (bus.ap_done) begin
          cap_lat_c = 1'b1;
          rec_lat_c = ts_q - start_ts_q;
          if (bus.ap_continue) begin
            push_c  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DONE_WAIT;
          end
        end
      end
      DONE_WAIT: begin
        if (bus.finish) begin
          push_c    = 1'b1;
          rec_inc_c = 1'b1;
          state_d   = FINISHED;
        end else if (bus.ap_done && bus.ap_continue) begin
          push_c  = 1'b1;
          state_d = IDLE;
        end
      end
      FINISHED: state_d = FINISHED;
      default:  state_d = IDLE;
    endcase
  end

`ifdef AP_TXN_STALL_COUNT_EN
  localparam int unsigned STALL_LSB = stall_lsb(TS_W);
  logic [TS_W-1:0] stall_q;
  logic            stall_inc_c;

  // A stall cycle is done held against a low continue without leaving the transaction
  assign stall_inc_c = (state_d == DONE_WAIT) & bus.ap_done & ~bus.ap_continue;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                              stall_q <= '0;
    else if (take_start_c)                  stall_q <= stall_inc_c ? TS_W'(1) : '0;
    else if (stall_inc_c && stall_q != '1)  stall_q <= stall_q + TS_W'(1);
  end
`endif

  always_comb begin
    rec_c                     = '0;
    rec_c[START_LSB +: TS_W]  = rec_start_c;
    rec_c[LAT_LSB +: TS_W]    = rec_lat_c;
    rec_c[IVL_LSB +: TS_W]    = rec_ivl_c;
`ifdef AP_TXN_STALL_COUNT_EN
    rec_c[STALL_LSB +: TS_W]  = take_start_c ? '0 : stall_q;
`endif
    rec_c[INC_BIT]            = rec_inc_c;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_q         <= '0;
      start_ts_q   <= '0;
      prev_start_q <= '0;
      prev_valid_q <= 1'b0;
      interval_q   <= '0;
      latency_q    <= '0;
      txn_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (take_start_c) begin
        start_ts_q   <= ts_q;
        prev_start_q <= ts_q;
        prev_valid_q <= 1'b1;
        interval_q   <= ivl_now_c;
        txn_cnt_q    <= txn_cnt_q + CNT_W'(1);
      end
      if (cap_lat_c) latency_q <= rec_lat_c;
      if (proto_c)   proto_err_q <= 1'b1;
      if (drop_c) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end
    end
  end

  assign pop_c  = ~empty_c & bus.rec_ready;
  assign drop_c = push_c & full_c & ~pop_c;

  sync_fifo_fwft #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_c),
    .wdata (rec_c),
    .pop   (pop_c),
    .rdata (bus.rec_data),
    .full  (full_c),
    .empty (empty_c),
    .level (bus.fifo_level)
  );

  assign bus.rec_valid = ~empty_c;
  assign bus.busy      = (state_q != IDLE);
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_cnt_q;
  assign bus.txn_cnt   = txn_cnt_q;
  assign bus.proto_err = proto_err_q;
endmodule

// File: tb/tb_ap_ctrl_txn_recorder.sv
// Bench for ap_ctrl_txn_recorder: transaction-level model plus directed and random stimulus.
module tb_ap_ctrl_txn_recorder;
  import ap_txn_pkg::*;

  localparam int unsigned TS_W    = 10;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned REC_W   = rec_w(TS_W);
  localparam int unsigned TS_MASK = (1 << TS_W) - 1;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ap_ctrl_txn_recorder_if #(.TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  ap_ctrl_txn_recorder #(.TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int unsigned st;
    int unsigned lat;
    int unsigned ivl;
    int unsigned stall;
    bit          inc;
  } rec_t;

  rec_t        q[$];
  int unsigned now = 0, t0 = 0, lat = 0, ivl = 0, stall = 0, prev_t0 = 0;
  int unsigned exp_txn = 0, exp_drop = 0;
  bit          in_txn = 0, have_done = 0, fin_mode = 0, have_prev = 0;
  bit          exp_ovf = 0, exp_perr = 0;
  bit          rdy_g = 0;
  int          n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [REC_W-1:0] pack(input rec_t r);
`ifdef AP_TXN_STALL_COUNT_EN
    return {r.inc, TS_W'(r.stall), TS_W'(r.ivl), TS_W'(r.lat), TS_W'(r.st)};
`else
    return {r.inc, TS_W'(r.ivl), TS_W'(r.lat), TS_W'(r.st)};
`endif
  endfunction

  function automatic logic [63:0] fld(input int lsb, input int w);
    return (64'(bus.rec_data) >> lsb) & ((64'd1 << w) - 64'd1);
  endfunction

  task automatic emit(input int unsigned l, input bit inc);
    rec_t r;
    r.st = t0; r.lat = l; r.ivl = ivl; r.stall = stall; r.inc = inc;
    if (q.size() < DEPTH) q.push_back(r);
    else begin
      exp_ovf = 1;
      if (exp_drop < CNT_MAX) exp_drop++;
    end
  endtask

  // Transaction-level reference: one step per clock using the inputs the DUT sees
  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      q.delete();
      now = 0; in_txn = 0; have_done = 0; fin_mode = 0; have_prev = 0;
      exp_txn = 0; exp_drop = 0; exp_ovf = 0; exp_perr = 0; stall = 0;
    end else begin
      if (q.size() != 0 && bus.rec_ready) void'(q.pop_front());
      if (!fin_mode) begin
        if (bus.finish) begin
          if (in_txn) emit(have_done ? lat : ((now - t0) & TS_MASK), 1'b1);
          in_txn = 0;
          fin_mode = 1;
        end else begin
          if (!in_txn && bus.ap_start) begin
            ivl = have_prev ? ((now - prev_t0) & TS_MASK) : 0;
            prev_t0 = now; have_prev = 1; t0 = now;
            exp_txn = (exp_txn + 1) & CNT_MAX;
            in_txn = 1; have_done = 0; stall = 0;
          end else if (!in_txn && (bus.ap_done || bus.ap_ready)) begin
            exp_perr = 1;
          end
          if (in_txn && bus.ap_done) begin
            if (!have_done) begin
              lat = (now - t0) & TS_MASK;
              have_done = 1;
            end
            if (bus.ap_continue) begin
              emit(lat, 1'b0);
              in_txn = 0;
            end else if (stall < TS_MASK) begin
              stall++;
            end
          end
        end
      end
      now = (now + 1) & TS_MASK;
    end
  end

  // Per-cycle comparison of every output against the model
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      check("rec_valid", bus.rec_valid, q.size() != 0);
      if (q.size() != 0) check("rec_data", bus.rec_data, pack(q[0]));
      check("fifo_level", bus.fifo_level, q.size());
      check("txn_cnt", bus.txn_cnt, exp_txn);
      check("drop_cnt", bus.drop_cnt, exp_drop);
      check("overflow", bus.overflow, exp_ovf);
      check("proto_err", bus.proto_err, exp_perr);
      check("busy", bus.busy, in_txn || fin_mode);
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic cyc(input bit s = 0, input bit d = 0, input bit c = 1,
                     input bit f = 0, input bit r = 0);
    bus.ap_start = s; bus.ap_done = d; bus.ap_continue = c;
    bus.finish = f; bus.ap_ready = r; bus.rec_ready = rdy_g;
    tick();
    bus.ap_start = 0; bus.ap_done = 0; bus.ap_continue = 1;
    bus.finish = 0; bus.ap_ready = 0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
  endtask

  task automatic wait_ts(input int unsigned target);
    int guard = 0;
    while (now != target && guard < 4096) begin
      cyc();
      guard++;
    end
    if (now != target) check("wait_ts_timeout", now, target);
  endtask

  logic [REC_W-1:0] held;

  initial begin
    bus.ap_start = 0; bus.ap_done = 0; bus.ap_continue = 1;
    bus.finish = 0; bus.ap_ready = 0; bus.rec_ready = 0;
    tick();
    reset_dut();
    check("rst_rec_valid", bus.rec_valid, 0);
    check("rst_level", bus.fifo_level, 0);
    check("rst_txn", bus.txn_cnt, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_perr", bus.proto_err, 0);
    check("rst_data", bus.rec_data, 0);

    // Two back-to-back completions held in the FIFO
    rdy_g = 0;
    wait_ts(10); cyc(.s(1));
    wait_ts(17); cyc(.d(1));
    check("t1_valid", bus.rec_valid, 1);
    check("t1_start", fld(0, TS_W), 10);
    check("t1_lat", fld(TS_W, TS_W), 7);
    check("t1_ivl", fld(2 * TS_W, TS_W), 0);
    check("t1_inc", fld(REC_W - 1, 1), 0);
    check("t1_txn", bus.txn_cnt, 1);
    wait_ts(30); cyc(.s(1));
    wait_ts(33); cyc(.d(1));
    check("t2_level", bus.fifo_level, 2);
    rdy_g = 1;
    cyc();
    check("t2_start", fld(0, TS_W), 30);
    check("t2_lat", fld(TS_W, TS_W), 3);
    check("t2_ivl", fld(2 * TS_W, TS_W), 20);
    cyc();

    // Done held against low continue
    wait_ts(36); cyc(.s(1));
    wait_ts(40);
    repeat (4) cyc(.d(1), .c(0));
    check("stall_level", bus.fifo_level, 0);
    check("stall_busy", bus.busy, 1);
    cyc(.d(1));
    check("stall_push", bus.rec_valid, 1);
    check("stall_lat", fld(TS_W, TS_W), 4);
    check("stall_ivl", fld(2 * TS_W, TS_W), 6);
`ifdef AP_TXN_STALL_COUNT_EN
    check("stall_cnt", fld(3 * TS_W, TS_W), 4);
`endif
    cyc();

    // Overflow: ten records into an eight-deep FIFO
    rdy_g = 0;
    repeat (10) begin
      cyc(.s(1)); cyc(.d(1)); cyc();
    end
    check("ovf_level", bus.fifo_level, 8);
    check("ovf_drop", bus.drop_cnt, 2);
    check("ovf_flag", bus.overflow, 1);
    check("ovf_head_lat", fld(TS_W, TS_W), 1);
    held = bus.rec_data;
    repeat (3) cyc();
    check("ovf_stable", bus.rec_data, held);
    rdy_g = 1;
    repeat (8) cyc();
    check("drain_level", bus.fifo_level, 0);
    check("drain_valid", bus.rec_valid, 0);

    // Random segments, each starting from reset
    for (int seg = 0; seg < 6; seg++) begin
      reset_dut();
      repeat (400) begin
        rdy_g = ($urandom % 3) != 0;
        cyc(.s(($urandom % 4) == 0), .d(($urandom % 3) == 0), .c(($urandom % 4) != 0),
            .f(($urandom % 500) == 0), .r(($urandom % 8) == 0));
      end
    end

    // Finish during RUN, then handshakes ignored
    reset_dut();
    rdy_g = 0;
    wait_ts(45); cyc(.s(1));
    wait_ts(50); cyc(.f(1));
    check("fin_valid", bus.rec_valid, 1);
    check("fin_inc", fld(REC_W - 1, 1), 1);
    check("fin_lat", fld(TS_W, TS_W), 5);
    check("fin_start", fld(0, TS_W), 45);
    cyc(.s(1)); cyc(.d(1)); cyc(.d(1), .r(1)); cyc();
    check("fin_txn", bus.txn_cnt, 1);
    check("fin_perr", bus.proto_err, 0);
    check("fin_level", bus.fifo_level, 1);
    check("fin_busy", bus.busy, 1);

    // Timestamp wrap, then protocol error stickiness
    reset_dut();
    rdy_g = 1;
    wait_ts(TS_MASK - 2); cyc(.s(1));
    wait_ts(2); cyc(.d(1));
    check("wrap_start", fld(0, TS_W), TS_MASK - 2);
    check("wrap_lat", fld(TS_W, TS_W), 5);
    check("perr_before", bus.proto_err, 0);
    cyc(.d(1));
    check("perr_set", bus.proto_err, 1);
    repeat (3) cyc();
    check("perr_sticky", bus.proto_err, 1);
    reset_dut();
    check("perr_cleared", bus.proto_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
